// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding, parity type codes and default widths.
// Used by uart_tx and uart_tx_fsm (optional parity build: UART_TX_PARITY_EN).
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PRESCALE_W_DEF = 6;
    localparam int PRESCALE_MIN   = 4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fsm.sv
// Transmit sequencer: state register, bit-cycle counter, data-bit index and acceptance decode.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
module uart_tx_fsm
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic [PRESCALE_W-1:0] prescale,
    output tx_state_e             state_q,
    output tx_state_e             state_d,
    output logic                  accept,
    output logic                  shift_en
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  last_cnt;
    logic                  last_idx;

    // prescale is the per-frame captured value, so a bit boundary never moves mid-frame
    assign last_cnt = (cnt_q == prescale - PRESCALE_W'(1));
    assign last_idx = (idx_q == LAST_IDX);

`ifndef UART_TX_PARITY_EN
    logic unused_par_en;
    assign unused_par_en = par_en;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = START;
            START: if (last_cnt) state_d = DATA;
            DATA: begin
                if (last_cnt && last_idx) begin
`ifdef UART_TX_PARITY_EN
                    state_d = par_en ? PARITY : STOP;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (last_cnt) state_d = STOP;
`endif
            STOP:    if (last_cnt) state_d = accept ? START : IDLE;
            default: state_d = IDLE;
        endcase

        cnt_d = (state_q == IDLE || last_cnt) ? '0 : cnt_q + PRESCALE_W'(1);

        idx_d = idx_q;
        if (state_q == DATA && last_cnt) begin
            idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Accept in IDLE, or in the final stop cycle so the next start bit follows with no gap
    always_comb begin
        accept   = data_valid && ((state_q == IDLE) || (state_q == STOP && last_cnt));
        shift_en = (state_q == DATA) && last_cnt && !last_idx;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter datapath: capture registers, shift register, parity and registered outputs.
// Define UART_TX_PARITY_EN to build the optional parity bit; otherwise PAR_EN/PAR_TYP are ignored.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic                  DATA_ACK
);

    tx_state_e             state_d;
    tx_state_e             fsm_state_unused;
    logic                  accept;
    logic                  shift_en;

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  ack_q, ack_d;
    logic                  par_en_cap;
    logic                  par_bit_tx;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_bit_q, par_bit_d;

    // Parity is fixed at capture time from the word that will actually be sent
    always_comb begin
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        if (accept) begin
            par_en_d  = PAR_EN;
            par_bit_d = (PAR_TYP == PAR_ODD) ? ~(^P_DATA) : (^P_DATA);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_en_q  <= 1'b0;
            par_bit_q <= PAR_EVEN;
        end else begin
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end

    assign par_en_cap = par_en_q;
    assign par_bit_tx = par_bit_d;
`else
    logic unused_par_in;
    assign unused_par_in = PAR_EN ^ PAR_TYP;
    assign par_en_cap    = 1'b0;
    assign par_bit_tx    = 1'b1;
`endif

    uart_tx_fsm #(
        .DATA_WIDTH (DATA_WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .data_valid (DATA_VALID),
        .par_en     (par_en_cap),
        .prescale   (pre_q),
        .state_q    (fsm_state_unused),
        .state_d    (state_d),
        .accept     (accept),
        .shift_en   (shift_en)
    );

    // Outputs are registered from the next state so the line changes on the same edge as the state
    always_comb begin
        shift_d = shift_q;
        pre_d   = pre_q;
        if (accept) begin
            shift_d = P_DATA;
            pre_d   = (Prescale < PRESCALE_W'(PRESCALE_MIN)) ? PRESCALE_W'(PRESCALE_MIN) : Prescale;
        end else if (shift_en) begin
            shift_d = shift_q >> 1;
        end

        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_bit_tx;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
        ack_d  = accept;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            pre_q   <= PRESCALE_W'(PRESCALE_MIN);
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            pre_q   <= pre_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign TX_OUT   = tx_q;
    assign Busy     = busy_q;
    assign DATA_ACK = ack_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven frames, hand-written corner sequences and random frames
// compared cycle by cycle against a bit-list model of the serial line.
module tb_uart_tx;

    localparam int DW = 8;
    localparam int PW = 6;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic          pe;
        logic          pt;
        int            psc;
        int            exp_bit_cyc;
        int            exp_nbits;
        logic          exp_par;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] p_data = '0;
    logic          data_valid = 1'b0;
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic [PW-1:0] prescale = PW'(8);
    logic          tx_out;
    logic          busy;
    logic          data_ack;

    logic [2:0] exp_q[$];
    int         ack_cyc_q[$];
    int         tests = 0;
    int         fails = 0;
    int         busy_cnt = 0;
    int         cyc = 0;
    vec_t       vecs[6];

    always #5 clk = ~clk;

    uart_tx #(
        .DATA_WIDTH (DW),
        .PRESCALE_W (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (p_data),
        .DATA_VALID (data_valid),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .Prescale   (prescale),
        .TX_OUT     (tx_out),
        .Busy       (busy),
        .DATA_ACK   (data_ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // Expected line: start bit, data LSB-first, optional parity, stop bit; each bit held max(psc,4) cycles.
    // Each entry is {TX_OUT, Busy, DATA_ACK} for one cycle after the acceptance edge.
    function automatic int model_frame(input logic [DW-1:0] d, input logic pe, input logic pt, input int psc);
        int   p;
        logic bits[$];
        p = (psc < 4) ? 4 : psc;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        if (pe && PAR_BUILT) bits.push_back((^d) ^ pt);
        bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++)
            for (int c = 0; c < p; c++)
                exp_q.push_back({bits[b], 1'b1, (b == 0 && c == 0)});
        return bits.size() * p;
    endfunction

    // One cycle: sample away from the active edge and compare with the model (idle when queue is empty)
    task automatic step();
        logic [2:0] exp;
        logic [2:0] act;
        @(negedge clk);
        cyc++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b100;
        act = {tx_out, busy, data_ack};
        if (busy) busy_cnt++;
        if (data_ack) ack_cyc_q.push_back(cyc);
        check("trace{tx,busy,ack}", 32'(act), 32'(exp));
    endtask

    task automatic run_frame(input vec_t v, input int idle_after);
        int   len;
        int   nbits;
        logic slot9;
        p_data     = v.data;
        par_en     = v.pe;
        par_typ    = v.pt;
        prescale   = PW'(v.psc);
        data_valid = 1'b1;
        len        = model_frame(v.data, v.pe, v.pt, v.psc);
        busy_cnt   = 0;
        slot9      = 1'bx;
        step();
        // Inputs changed after acceptance must not disturb the frame in flight
        data_valid = 1'b0;
        p_data     = ~v.data;
        par_en     = 1'($urandom_range(0, 1));
        par_typ    = 1'($urandom_range(0, 1));
        prescale   = PW'($urandom_range(0, 63));
        for (int i = 1; i < len; i++) begin
            step();
            if (i == 9 * v.exp_bit_cyc + v.exp_bit_cyc / 2) slot9 = tx_out;
        end
        for (int i = 0; i < idle_after; i++) step();
        nbits = v.exp_nbits - ((v.pe && !PAR_BUILT) ? 1 : 0);
        check("busy_len", 32'(busy_cnt), 32'(nbits * v.exp_bit_cyc));
        check("slot9_parity_or_stop", 32'(slot9), 32'((v.pe && PAR_BUILT) ? v.exp_par : 1'b1));
    endtask

    initial begin
        int   l1;
        int   l2;
        vec_t r;

        vecs[0] = '{data: 8'hA5, pe: 1'b1, pt: 1'b0, psc: 8,  exp_bit_cyc: 8,  exp_nbits: 11, exp_par: 1'b0};
        vecs[1] = '{data: 8'hA5, pe: 1'b1, pt: 1'b1, psc: 8,  exp_bit_cyc: 8,  exp_nbits: 11, exp_par: 1'b1};
        vecs[2] = '{data: 8'h3C, pe: 1'b0, pt: 1'b0, psc: 16, exp_bit_cyc: 16, exp_nbits: 10, exp_par: 1'b0};
        vecs[3] = '{data: 8'h01, pe: 1'b0, pt: 1'b0, psc: 2,  exp_bit_cyc: 4,  exp_nbits: 10, exp_par: 1'b0};
        vecs[4] = '{data: 8'h00, pe: 1'b1, pt: 1'b1, psc: 4,  exp_bit_cyc: 4,  exp_nbits: 11, exp_par: 1'b1};
        vecs[5] = '{data: 8'hFF, pe: 1'b1, pt: 1'b0, psc: 63, exp_bit_cyc: 63, exp_nbits: 11, exp_par: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx_out), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ack", 32'(data_ack), 32'd0);
        rst = 1'b1;
        repeat (3) step();

        for (int i = 0; i < 6; i++) run_frame(vecs[i], 2);

        // Back-to-back: DATA_VALID held high, data switched after the first acknowledge
        ack_cyc_q.delete();
        p_data     = 8'h55;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        prescale   = PW'(8);
        data_valid = 1'b1;
        l1         = model_frame(8'h55, 1'b0, 1'b0, 8);
        l2         = model_frame(8'hFF, 1'b0, 1'b0, 8);
        busy_cnt   = 0;
        step();
        p_data = 8'hFF;
        for (int i = 1; i < l1; i++) step();
        step();
        data_valid = 1'b0;
        p_data     = 8'(($urandom));
        for (int i = 1; i < l2; i++) step();
        repeat (3) step();
        check("b2b_busy_len", 32'(busy_cnt), 32'd160);
        check("b2b_ack_count", 32'(ack_cyc_q.size()), 32'd2);
        if (ack_cyc_q.size() == 2)
            check("b2b_ack_spacing", 32'(ack_cyc_q[1] - ack_cyc_q[0]), 32'd80);

        // Reset in the middle of data bit 3 abandons the frame
        p_data     = 8'(($urandom));
        par_en     = 1'b0;
        prescale   = PW'(8);
        data_valid = 1'b1;
        l1         = model_frame(p_data, 1'b0, 1'b0, 8);
        step();
        data_valid = 1'b0;
        for (int i = 1; i <= 34; i++) step();
        rst = 1'b0;
        #1;
        check("midreset_tx", 32'(tx_out), 32'd1);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_ack", 32'(data_ack), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (4) step();
        run_frame('{data: 8'hC3, pe: 1'b1, pt: 1'b0, psc: 8, exp_bit_cyc: 8, exp_nbits: 11, exp_par: 1'b0}, 2);

        // Random frames; a zero idle gap lands the request on the last stop cycle (back-to-back)
        for (int n = 0; n < 10; n++) begin
            r.data        = 8'($urandom);
            r.pe          = 1'($urandom_range(0, 1));
            r.pt          = 1'($urandom_range(0, 1));
            r.psc         = $urandom_range(0, 12);
            r.exp_bit_cyc = (r.psc < 4) ? 4 : r.psc;
            r.exp_nbits   = r.pe ? 11 : 10;
            r.exp_par     = (^r.data) ^ r.pt;
            run_frame(r, $urandom_range(0, 3));
        end
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
